// File: rtl/execute_muldiv_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M unit.
// The pipeline side is the master; the multiply/divide unit is the slave.
interface execute_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic [4:0]            rd_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic [4:0]            rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign and special cases fixed at the end.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  execute_muldiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [W-1:0]    mag_q;
  logic [W-1:0]    rs1_q;
  logic [2*W-1:0]  acc_q;
  logic            neg_q, rs1_neg_q, div_zero_q, ovf_q;
  logic            done_q;
  logic [W-1:0]    result_q;
  logic [4:0]      rd_out_q;

  logic            sgn_a, sgn_b, a_neg, b_neg, start_ok;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum, diff;
  logic [2*W-1:0]  acc_nx, prod;
  logic [W-1:0]    quo, rem, final_res;

  // rs1 is signed for everything except MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU.
  assign sgn_a    = !(bus.op_i[0] && (bus.op_i[1] || bus.op_i[2]));
  assign sgn_b    = sgn_a && (bus.op_i != 3'b010);
  assign a_neg    = sgn_a && bus.rs1_i[W-1];
  assign b_neg    = sgn_b && bus.rs2_i[W-1];
  assign a_mag    = a_neg ? -bus.rs1_i : bus.rs1_i;
  assign b_mag    = b_neg ? -bus.rs2_i : bus.rs2_i;
  assign start_ok = (state_q == IDLE) && bus.start_i && !bus.flush_i;

  assign bus.busy_o   = start_ok || (state_q == CALC);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mag_q};
    diff = acc_q[2*W-1:W-1] - {1'b0, mag_q};
    if (!op_q[2]) begin
      acc_nx = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    end else begin
      acc_nx = diff[W] ? {acc_q[2*W-2:0], 1'b0} : {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem  = rs1_neg_q ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    if (div_zero_q) begin
      quo = '1;
      rem = rs1_q;
    end else if (ovf_q) begin
      quo = rs1_q;
      rem = '0;
    end
    case (op_q)
      3'b000:                 final_res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*W-1:W];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: only control and output registers are reset; the datapath is always
      // reloaded on start before it is read.
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            op_q       <= bus.op_i;
            rd_q       <= bus.rd_i;
            rs1_q      <= bus.rs1_i;
            mag_q      <= bus.op_i[2] ? b_mag : a_mag;
            acc_q      <= {{W{1'b0}}, (bus.op_i[2] ? a_mag : b_mag)};
            neg_q      <= a_neg ^ b_neg;
            rs1_neg_q  <= a_neg;
            div_zero_q <= (bus.rs2_i == '0);
            ovf_q      <= bus.op_i[2] && !bus.op_i[0] &&
                          (bus.rs1_i == {1'b1, {(W-1){1'b0}}}) && (bus.rs2_i == '1);
            cnt_q      <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= final_res;
              rd_out_q <= rd_q;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed RV32M cases, flush/reset
// behaviour and randomized operations against an arithmetic reference model.
module tb_execute_muldiv;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  execute_muldiv_if #(.DATA_WIDTH(32)) bus ();
  execute_muldiv #(.DATA_WIDTH(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p;
    logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called shortly after a rising edge; that cycle is cycle 0 of the operation.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit hold,
                        input string tag);
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          busy_err = 0;
    logic [31:0] res = 'x;
    logic [4:0]  rdo = 'x;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    bus.flush_i = 1'b0;
    #1;
    if (bus.busy_o !== 1'b1) busy_err++;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(posedge clk_i);
      #1;
      bus.start_i = hold && (cyc <= 33);
      bus.op_i    = 3'($urandom);
      bus.rs1_i   = $urandom;
      bus.rs2_i   = $urandom;
      bus.rd_i    = 5'($urandom);
      #1;
      if (bus.busy_o !== (cyc <= 32)) busy_err++;
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res      = bus.result_o;
          rdo      = bus.rd_o;
        end
      end
    end
    bus.start_i = 1'b0;
    check({tag, "/done_cycle"}, 32'(done_cyc), 32'd33);
    check({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "/result"}, res, exp);
    check({tag, "/rd"}, {27'b0, rdo}, {27'b0, rd});
    check({tag, "/busy_cycles_wrong"}, 32'(busy_err), 32'd0);
    check({tag, "/result_held"}, bus.result_o, exp);
  endtask

  initial begin
    logic [31:0] a, b, exp;
    logic [2:0]  op;
    int          busy_err, done_cnt;

    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rd_i    = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset/busy", {31'b0, bus.busy_o}, 32'd0);
    check("reset/done", {31'b0, bus.done_o}, 32'd0);
    check("reset/result", bus.result_o, 32'd0);
    check("reset/rd", {27'b0, bus.rd_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, "mul_7x-3_hold");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0, "mulhsu_-1x2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b0, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 1'b0, "remu_100/7");
    run_op(3'd4, 32'd42, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b0, "div_by_zero");
    run_op(3'd6, 32'd42, 32'd0, 5'd10, 32'd42, 1'b0, "rem_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0, "rem_overflow");

    // Flush during CALC: previous result (0, rd 12) must survive.
    bus.start_i = 1'b1;
    bus.op_i    = 3'd4;
    bus.rs1_i   = 32'd1000;
    bus.rs2_i   = 32'd3;
    bus.rd_i    = 5'd20;
    busy_err    = 0;
    done_cnt    = 0;
    #1;
    if (bus.busy_o !== 1'b1) busy_err++;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = (cyc == 10);
      #1;
      if (bus.busy_o !== (cyc <= 10)) busy_err++;
      if (bus.done_o !== 1'b0) done_cnt++;
    end
    bus.flush_i = 1'b0;
    check("flush/busy_cycles_wrong", 32'(busy_err), 32'd0);
    check("flush/done_pulses", 32'(done_cnt), 32'd0);
    check("flush/result_kept", bus.result_o, 32'd0);
    check("flush/rd_kept", {27'b0, bus.rd_o}, 32'd12);
    @(posedge clk_i);
    #1;
    run_op(3'd5, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b0, "after_flush_divu");

    // start with flush in IDLE is ignored.
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'd5;
    bus.rs2_i   = 32'd5;
    busy_err    = 0;
    done_cnt    = 0;
    #1;
    if (bus.busy_o !== 1'b0) busy_err++;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      #1;
      if (bus.busy_o !== 1'b0) busy_err++;
      if (bus.done_o !== 1'b0) done_cnt++;
    end
    check("idle_flush/busy_cycles_wrong", 32'(busy_err), 32'd0);
    check("idle_flush/done_pulses", 32'(done_cnt), 32'd0);
    check("idle_flush/result_kept", bus.result_o, 32'd333);

    // Reset at cycle 20 of a MUL clears everything on the next edge.
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'd123;
    bus.rs2_i   = 32'd456;
    bus.rd_i    = 5'd30;
    done_cnt    = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      rst_i       = (cyc == 20);
      #1;
      if (bus.done_o !== 1'b0) done_cnt++;
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("midreset/busy", {31'b0, bus.busy_o}, 32'd0);
    check("midreset/done", {31'b0, bus.done_o}, 32'd0);
    check("midreset/result", bus.result_o, 32'd0);
    check("midreset/rd", {27'b0, bus.rd_o}, 32'd0);
    for (int cyc = 22; cyc <= 40; cyc++) begin
      @(posedge clk_i);
      #2;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) done_cnt++;
    end
    check("midreset/activity_after", 32'(done_cnt), 32'd0);
    @(posedge clk_i);
    #1;

    // Randomized operations with boundary operands mixed in.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       a = 32'h0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      exp = ref_model(op, a, b);
      run_op(op, a, b, 5'($urandom), exp, 1'($urandom_range(0, 1)),
             $sformatf("rand%0d_op%0d_%h_%h", n, op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
